// File: rtl/game_pkg.sv
// Shared types and constants for the obstacle game sequencer.
//
// Contents:
//   NUM_SHAPES_DEF  default number of obstacle shapes. The obstacle datapath
//                   uses the same value.
//   LEVEL_W         level width for the default shape count.
//   LIVES_W         width of the lives counter.
//   game_state_t    sequencer state encoding.
//
// Configuration macro: GAME_PAUSE_EN. When it is defined, the encoding gains
// the ST_PAUSED state. When it is undefined, ST_PAUSED does not exist.
package game_pkg;

  localparam int NUM_SHAPES_DEF = 4;
  localparam int LEVEL_W        = $clog2(NUM_SHAPES_DEF);
  localparam int LIVES_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_HIT_FREEZE = 3'd2,
    ST_LEVEL_UP   = 3'd3,
    ST_GAME_OVER  = 3'd4
`ifdef GAME_PAUSE_EN
    , ST_PAUSED   = 3'd5
`endif
  } game_state_t;

endpackage

// File: rtl/game_frame_timer.sv
// Loadable down-counter that advances on frame ticks. The sequencer uses it
// for both the hit-freeze wait and the level-up banner wait.
//
// Ports:
//   clk, reset  system clock and synchronous active-high reset
//   load        loads load_val. A tick in the same cycle is not counted.
//   load_val    number of frame ticks to wait (>=1)
//   en          counting is allowed (the owner is in a timed phase)
//   tick        one-cycle frame pulse
//   done        one-cycle pulse on the tick that brings the count to zero
module game_frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;

  // Remaining-tick counter: a load wins over a tick, and the counter stops at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && tick && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // done is combinational so the owner leaves on the very tick that empties the count.
  assign done = en && tick && !load && (cnt_r == CNT_W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: idle, play, hit-freeze, level-up banner and
// game-over phases. It tracks lives, score and level, and drives the obstacle
// datapath with the shape mask, the speed and an obstacle restart pulse.
//
// Ports:
//   clk, reset   system clock and synchronous active-high reset
//   frame_tick   one pulse per video frame. It paces the freeze and banner waits.
//   start_btn    press pulse. It starts a game from idle and leaves game-over.
//   obj_wrap     an obstacle has been passed
//   hit          the player collided with an obstacle
//   pause_btn    toggles pause during play (only with GAME_PAUSE_EN)
//   level        current level, 0-based
//   shape_en     thermometer mask of active shapes
//   speed        obstacle speed, equal to level+1
//   lives        remaining lives
//   score        count of passed obstacles, saturating
//   obj_rst      one-cycle pulse on every fresh entry into play
//   game_over    high while in the game-over phase
//   banner       high while the level-up banner is shown
//
// Configuration macro: GAME_PAUSE_EN adds the PAUSED state. Without it,
// pause_btn is unused.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_SHAPES      = NUM_SHAPES_DEF,
  parameter int WRAPS_PER_LEVEL = 3,
  parameter int START_LIVES     = 3,
  parameter int FREEZE_FRAMES   = 60,
  parameter int BANNER_FRAMES   = 90,
  parameter int SCORE_W         = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          start_btn,
  input  logic                          obj_wrap,
  input  logic                          hit,
  input  logic                          pause_btn,
  output logic [$clog2(NUM_SHAPES)-1:0] level,
  output logic [NUM_SHAPES-1:0]         shape_en,
  output logic [2:0]                    speed,
  output logic [2:0]                    lives,
  output logic [SCORE_W-1:0]            score,
  output logic                          obj_rst,
  output logic                          game_over,
  output logic                          banner
);

  localparam int LW = $clog2(NUM_SHAPES);
  localparam int WW = (WRAPS_PER_LEVEL > 1) ? $clog2(WRAPS_PER_LEVEL) : 1;
  localparam int TW = $clog2(((FREEZE_FRAMES > BANNER_FRAMES) ? FREEZE_FRAMES : BANNER_FRAMES) + 1);

  localparam logic [LW-1:0]      LEVEL_MAX   = LW'(NUM_SHAPES - 1);
  localparam logic [WW-1:0]      WRAP_LAST   = WW'(WRAPS_PER_LEVEL - 1);
  localparam logic [TW-1:0]      FREEZE_LOAD = TW'(FREEZE_FRAMES);
  localparam logic [TW-1:0]      BANNER_LOAD = TW'(BANNER_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};

  game_state_t        state_r, state_nx;
  logic [LW-1:0]      level_r, level_nx;
  logic [LIVES_W-1:0] lives_r, lives_nx;
  logic [SCORE_W-1:0] score_r, score_nx;
  logic [WW-1:0]      wrap_r, wrap_nx;

  logic               tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]      tmr_val;

  logic [NUM_SHAPES-1:0] shape_en_nx;
  logic [2:0]            speed_nx;
  logic                  obj_rst_nx, game_over_nx, banner_nx, shape_act;

  // Builds a thermometer mask with bits 0..lvl set.
  function automatic logic [NUM_SHAPES-1:0] therm(input logic [LW-1:0] lvl);
    logic [NUM_SHAPES-1:0] m;
    m = {NUM_SHAPES{1'b0}};
    for (int i = 0; i < NUM_SHAPES; i++) begin
      m[i] = (i <= int'(lvl));
    end
    return m;
  endfunction

  assign tmr_en = (state_r == ST_HIT_FREEZE) || (state_r == ST_LEVEL_UP);

  game_frame_timer #(
    .CNT_W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tick     (frame_tick),
    .done     (tmr_done)
  );

`ifndef GAME_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif

  // State register plus registered copies of every output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      level_r   <= {LW{1'b0}};
      lives_r   <= {LIVES_W{1'b0}};
      score_r   <= {SCORE_W{1'b0}};
      wrap_r    <= {WW{1'b0}};
      shape_en  <= {NUM_SHAPES{1'b0}};
      speed     <= 3'd1;
      obj_rst   <= 1'b0;
      game_over <= 1'b0;
      banner    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      level_r   <= level_nx;
      lives_r   <= lives_nx;
      score_r   <= score_nx;
      wrap_r    <= wrap_nx;
      shape_en  <= shape_en_nx;
      speed     <= speed_nx;
      obj_rst   <= obj_rst_nx;
      game_over <= game_over_nx;
      banner    <= banner_nx;
    end
  end

  // Next state and counter updates. In play, a hit takes priority over a wrap in the same cycle.
  always_comb begin
    state_nx = state_r;
    level_nx = level_r;
    lives_nx = lives_r;
    score_nx = score_r;
    wrap_nx  = wrap_r;
    tmr_load = 1'b0;
    tmr_val  = {TW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start_btn) begin
          state_nx = ST_PLAY;
          lives_nx = LIVES_INIT;
          score_nx = {SCORE_W{1'b0}};
          level_nx = {LW{1'b0}};
          wrap_nx  = {WW{1'b0}};
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          lives_nx = lives_r - LIVES_W'(1);
          wrap_nx  = {WW{1'b0}};
          if (lives_r == LIVES_W'(1)) begin
            state_nx = ST_GAME_OVER;
          end else begin
            state_nx = ST_HIT_FREEZE;
            tmr_load = 1'b1;
            tmr_val  = FREEZE_LOAD;
          end
        end else if (obj_wrap) begin
          if (score_r != SCORE_MAX) begin
            score_nx = score_r + SCORE_W'(1);
          end else begin
            score_nx = score_r;
          end
          if (wrap_r != WRAP_LAST) begin
            wrap_nx = wrap_r + WW'(1);
          end else begin
            wrap_nx = {WW{1'b0}};
            // At the top level the wrap count keeps cycling, but no banner is shown.
            if (level_r < LEVEL_MAX) begin
              level_nx = level_r + LW'(1);
              state_nx = ST_LEVEL_UP;
              tmr_load = 1'b1;
              tmr_val  = BANNER_LOAD;
            end else begin
              state_nx = ST_PLAY;
            end
          end
`ifdef GAME_PAUSE_EN
        end else if (pause_btn) begin
          state_nx = ST_PAUSED;
`endif
        end else begin
          state_nx = ST_PLAY;
        end
      end
      ST_HIT_FREEZE, ST_LEVEL_UP: begin
        if (tmr_done) begin
          state_nx = ST_PLAY;
        end else begin
          state_nx = state_r;
        end
      end
      ST_GAME_OVER: begin
        // Score and level remain visible until the player acknowledges with start.
        if (start_btn) begin
          state_nx = ST_IDLE;
          score_nx = {SCORE_W{1'b0}};
          level_nx = {LW{1'b0}};
          wrap_nx  = {WW{1'b0}};
        end else begin
          state_nx = ST_GAME_OVER;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        if (pause_btn) begin
          state_nx = ST_PLAY;
        end else begin
          state_nx = ST_PAUSED;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
        level_nx = {LW{1'b0}};
        lives_nx = {LIVES_W{1'b0}};
        score_nx = {SCORE_W{1'b0}};
        wrap_nx  = {WW{1'b0}};
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so that they line up with it.
  always_comb begin
    shape_act = (state_nx == ST_PLAY) || (state_nx == ST_HIT_FREEZE);
`ifdef GAME_PAUSE_EN
    shape_act = shape_act || (state_nx == ST_PAUSED);
    obj_rst_nx = (state_nx == ST_PLAY) && (state_r != ST_PLAY) && (state_r != ST_PAUSED);
`else
    obj_rst_nx = (state_nx == ST_PLAY) && (state_r != ST_PLAY);
`endif
    if (shape_act) begin
      shape_en_nx = therm(level_nx);
    end else begin
      shape_en_nx = {NUM_SHAPES{1'b0}};
    end
    speed_nx     = 3'(level_nx) + 3'd1;
    game_over_nx = (state_nx == ST_GAME_OVER);
    banner_nx    = (state_nx == ST_LEVEL_UP);
  end

  assign level = level_r;
  assign lives = lives_r;
  assign score = score_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with its default parameters.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start_btn, obj_wrap, hit, pause_btn;
  logic [1:0] level;
  logic [3:0] shape_en;
  logic [2:0] speed, lives;
  logic [9:0] score;
  logic       obj_rst, game_over, banner;

  typedef struct packed {
    logic [1:0] lvl;
    logic [3:0] sh;
    logic [2:0] spd;
    logic [2:0] lv;
    logic [9:0] sc;
    logic       orst;
    logic       gov;
    logic       ban;
  } exp_t;

  typedef struct {
    logic st, wr, ht, ps, tk;
    int   lvl, lv, sc;
    bit   orst, gov, ban, act;
  } vec_t;

  exp_t exp_q[$];
  int   tag_q[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[13];

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .obj_wrap   (obj_wrap),
    .hit        (hit),
    .pause_btn  (pause_btn),
    .level      (level),
    .shape_en   (shape_en),
    .speed      (speed),
    .lives      (lives),
    .score      (score),
    .obj_rst    (obj_rst),
    .game_over  (game_over),
    .banner     (banner)
  );

  // Expected outputs: shape mask is a thermometer up to lvl in active phases, speed is lvl+1.
  function automatic exp_t mk(int lvl, int lv, int sc, bit orst, bit gov, bit ban, bit act);
    exp_t e;
    logic [3:0] th;
    th     = 4'((1 << (lvl + 1)) - 1);
    e.lvl  = 2'(lvl);
    e.sh   = act ? th : 4'd0;
    e.spd  = 3'(lvl + 1);
    e.lv   = 3'(lv);
    e.sc   = 10'(sc);
    e.orst = orst;
    e.gov  = gov;
    e.ban  = ban;
    return e;
  endfunction

  task automatic check_out();
    exp_t g, e;
    int   t;
    g = {level, shape_en, speed, lives, score, obj_rst, game_over, banner};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%h required=an expected entry", g);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (g !== e) begin
        bad++;
        $display("FAIL step tag=%0d got lvl=%0d sh=%b spd=%0d lives=%0d score=%0d orst=%b gov=%b ban=%b required lvl=%0d sh=%b spd=%0d lives=%0d score=%0d orst=%b gov=%b ban=%b",
                 t, g.lvl, g.sh, g.spd, g.lv, g.sc, g.orst, g.gov, g.ban,
                 e.lvl, e.sh, e.spd, e.lv, e.sc, e.orst, e.gov, e.ban);
      end
    end
  endtask

  // Drives one cycle of stimulus, queues its expectation, and checks just after the edge.
  task automatic step(input logic st, input logic wr, input logic ht, input logic ps,
                      input logic tk, input exp_t e, input int tag);
    start_btn  = st;
    obj_wrap   = wr;
    hit        = ht;
    pause_btn  = ps;
    frame_tick = tk;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    start_btn  = 1'b0;
    obj_wrap   = 1'b0;
    hit        = 1'b0;
    pause_btn  = 1'b0;
    frame_tick = 1'b0;
    check_out();
  endtask

  task automatic ticks(input int n, input exp_t e, input int tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e, tag);
    end
  endtask

  initial begin
    // st wr ht ps tk | lvl lives score | orst gov ban act
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; obj_wrap = 1'b0;
    hit = 1'b0; pause_btn = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0), 2);
    reset = 1'b0;

    // Idle, start, first level-up and the first banner tick.
    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].wr, tbl[i].ht, tbl[i].ps, tbl[i].tk,
           mk(tbl[i].lvl, tbl[i].lv, tbl[i].sc, tbl[i].orst, tbl[i].gov, tbl[i].ban, tbl[i].act),
           100 + i);
    end

    // The banner lasts exactly 90 ticks, then play resumes with a restart pulse.
    ticks(88, mk(1, 3, 3, 1'b0, 1'b0, 1'b1, 1'b0), 20);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1, 3, 3, 1'b1, 1'b0, 1'b0, 1'b1), 21);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1), 22);

    // A hit clears the partial wrap count. A tick in the hit cycle is not counted.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 3, 4, 1'b0, 1'b0, 1'b0, 1'b1), 23);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(1, 2, 4, 1'b0, 1'b0, 1'b0, 1'b1), 24);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1, 2, 4, 1'b0, 1'b0, 1'b0, 1'b1), 25);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 2, 4, 1'b0, 1'b0, 1'b0, 1'b1), 26);
    ticks(59, mk(1, 2, 4, 1'b0, 1'b0, 1'b0, 1'b1), 27);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1, 2, 4, 1'b1, 1'b0, 1'b0, 1'b1), 28);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 2, 5, 1'b0, 1'b0, 1'b0, 1'b1), 29);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 2, 6, 1'b0, 1'b0, 1'b0, 1'b1), 30);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(2, 2, 7, 1'b0, 1'b0, 1'b1, 1'b0), 31);
    ticks(89, mk(2, 2, 7, 1'b0, 1'b0, 1'b1, 1'b0), 32);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(2, 2, 7, 1'b1, 1'b0, 1'b0, 1'b1), 33);

    // Climb to level 3. Further wraps only add to the score.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(2, 2, 8, 1'b0, 1'b0, 1'b0, 1'b1), 34);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(2, 2, 9, 1'b0, 1'b0, 1'b0, 1'b1), 34);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(3, 2, 10, 1'b0, 1'b0, 1'b1, 1'b0), 34);
    ticks(89, mk(3, 2, 10, 1'b0, 1'b0, 1'b1, 1'b0), 35);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(3, 2, 10, 1'b1, 1'b0, 1'b0, 1'b1), 36);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(3, 2, 11 + k, 1'b0, 1'b0, 1'b0, 1'b1), 37);
    end

    // Hit together with a wrap: the hit wins and the wrap is dropped.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(3, 1, 13, 1'b0, 1'b0, 1'b0, 1'b1), 38);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(3, 1, 13, 1'b0, 1'b0, 1'b0, 1'b1), 39);
    ticks(59, mk(3, 1, 13, 1'b0, 1'b0, 1'b0, 1'b1), 40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(3, 1, 13, 1'b1, 1'b0, 1'b0, 1'b1), 41);

    // The score saturates at all-ones.
    for (int s = 14; s <= 1023; s++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(3, 1, s, 1'b0, 1'b0, 1'b0, 1'b1), 42);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(3, 1, 1023, 1'b0, 1'b0, 1'b0, 1'b1), 43);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(3, 1, 1023, 1'b0, 1'b0, 1'b0, 1'b1), 43);

    // The last life ends the game. Score and level are held until start is pressed.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(3, 0, 1023, 1'b0, 1'b1, 1'b0, 1'b0), 44);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, mk(3, 0, 1023, 1'b0, 1'b1, 1'b0, 1'b0), 45);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0), 46);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1), 47);

`ifdef GAME_PAUSE_EN
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1), 48);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1), 49);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1), 49);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1), 50);
`else
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1), 48);
`endif
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 3, 1, 1'b0, 1'b0, 1'b0, 1'b1), 51);

    // A reset in the middle of a game returns everything to the reset state.
    reset = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0), 52);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0), 53);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1), 54);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
